sdram_arbiter: RTL and testbench

Shares the single SDRAM controller command port between the sample writer (requester 0) and the USB host bridge (requester 1), and schedules periodic auto-refresh. Sits between the capture/USB logic and the SDRAM controller that drives the m_* pins. Arbitrates one command at a time, tracks outstanding reads in order and routes returned read data back to the requester that issued each read.

---
 rtl/sdram_arbiter_if.sv | 51 +++++
 rtl/sdram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Requester, SDRAM-controller command and read-return signals around sdram_arbiter.
// slave = arbiter side, master = surrounding requesters/controller.
interface sdram_arbiter_if #(
   parameter int unsigned ADDR_W = 24
);
   logic              r0_req;
   logic              r0_we;
   logic [ADDR_W-1:0] r0_addr;
   logic [15:0]       r0_wdata;
   logic              r0_gnt;
   logic              r0_rvalid;

   logic              r1_req;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [15:0]       r1_wdata;
   logic              r1_gnt;
   logic              r1_rvalid;

   logic [15:0]       r_rdata;

   logic              m_valid;
   logic              m_ready;
   logic              m_refresh;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [15:0]       m_wdata;
   logic              m_rvalid;
   logic [15:0]       m_rdata;

   logic              err_ref_overrun;
   logic              err_orphan;

   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      input  m_ready, m_rvalid, m_rdata,
      output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, r_rdata,
      output m_valid, m_refresh, m_we, m_addr, m_wdata,
      output err_ref_overrun, err_orphan
   );

   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      output m_ready, m_rvalid, m_rdata,
      input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, r_rdata,
      input  m_valid, m_refresh, m_we, m_addr, m_wdata,
      input  err_ref_overrun, err_orphan
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-requester SDRAM command arbiter with auto-refresh scheduling and in-order read-return routing.
// Optional starvation override for requester 1 enabled by defining SDRAM_ARB_STARVE_EN.
module sdram_arbiter #(
   parameter int unsigned ADDR_W         = 24,
   parameter int unsigned REFRESH_PERIOD = 515
`ifdef SDRAM_ARB_STARVE_EN
   ,
   parameter int unsigned STARVE_LIMIT   = 16
`endif
) (
   input logic            clk,
   input logic            rst,
   sdram_arbiter_if.slave bus
);

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned REF_W      = $clog2(REFRESH_PERIOD + 1);
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned PTR_W      = 2;
   localparam int unsigned CNT_W      = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, CMD, REF} state_e;

   state_e              state_q;
   logic                m_valid_q;
   logic                m_refresh_q;
   logic                m_we_q;
   logic [ADDR_W-1:0]   m_addr_q;
   logic [DATA_W-1:0]   m_wdata_q;
   logic                owner_q;

   logic [REF_W-1:0]    ref_cnt_q;
   logic                ref_pend_q;
   logic                err_ovr_q;
   logic                err_orph_q;

   logic                tag_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;

   logic accept, cmd_accept, ref_accept, ref_due;
   logic push, pop, fifo_full, fifo_empty, head_tag;
   logic r0_elig, r1_elig, sel_any, sel_r1, starve_hit;
   logic r0_gnt, r1_gnt;

   assign accept     = m_valid_q && bus.m_ready;
   assign cmd_accept = accept && !m_refresh_q;
   assign ref_accept = accept && m_refresh_q;
   assign ref_due    = (ref_cnt_q == '0);

   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = cmd_accept && !m_we_q;
   assign pop        = bus.m_rvalid && !fifo_empty;
   assign head_tag   = tag_q[rd_ptr_q];

   // Reads need a free tag slot at decision time; writes never block.
   assign r0_elig = bus.r0_req && (bus.r0_we || !fifo_full);
   assign r1_elig = bus.r1_req && (bus.r1_we || !fifo_full);
   assign sel_any = r0_elig || r1_elig;
   assign sel_r1  = r1_elig && (starve_hit || !r0_elig);

   assign r0_gnt = cmd_accept && !owner_q;
   assign r1_gnt = cmd_accept && owner_q;

`ifdef SDRAM_ARB_STARVE_EN
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] starve_q;

   assign starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));

   // Counts requester-0 wins while requester 1 is waiting; saturates at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else if (!bus.r1_req || r1_gnt) begin
         starve_q <= '0;
      end else if (r0_gnt && !starve_hit) begin
         starve_q <= starve_q + 1'b1;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   // Command FSM: latch the chosen command, hold it until the controller takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         m_valid_q   <= 1'b0;
         m_refresh_q <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         owner_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ref_pend_q) begin
                  state_q     <= REF;
                  m_valid_q   <= 1'b1;
                  m_refresh_q <= 1'b1;
               end else if (sel_any) begin
                  state_q     <= CMD;
                  m_valid_q   <= 1'b1;
                  m_refresh_q <= 1'b0;
                  owner_q     <= sel_r1;
                  m_we_q      <= sel_r1 ? bus.r1_we    : bus.r0_we;
                  m_addr_q    <= sel_r1 ? bus.r1_addr  : bus.r0_addr;
                  m_wdata_q   <= sel_r1 ? bus.r1_wdata : bus.r0_wdata;
               end
            end
            CMD, REF: begin
               if (bus.m_ready) begin
                  state_q     <= IDLE;
                  m_valid_q   <= 1'b0;
                  m_refresh_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               m_valid_q   <= 1'b0;
               m_refresh_q <= 1'b0;
            end
         endcase
      end
   end

   // Refresh timer; a new due event wins over a same-cycle refresh acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt_q  <= REF_W'(REFRESH_PERIOD - 1);
         ref_pend_q <= 1'b0;
         err_ovr_q  <= 1'b0;
      end else begin
         if (ref_due) begin
            ref_cnt_q  <= REF_W'(REFRESH_PERIOD - 1);
            ref_pend_q <= 1'b1;
            if (ref_pend_q) begin
               err_ovr_q <= 1'b1;
            end
         end else begin
            ref_cnt_q <= ref_cnt_q - 1'b1;
            if (ref_accept) begin
               ref_pend_q <= 1'b0;
            end
         end
      end
   end

   // Read tag FIFO: records which requester owns each outstanding read, in issue order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            tag_q[i] <= 1'b0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_orph_q <= 1'b0;
      end else begin
         if (push) begin
            tag_q[wr_ptr_q] <= owner_q;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (bus.m_rvalid && fifo_empty) begin
            err_orph_q <= 1'b1;
         end
      end
   end

   assign bus.m_valid         = m_valid_q;
   assign bus.m_refresh       = m_refresh_q;
   assign bus.m_we            = m_we_q;
   assign bus.m_addr          = m_addr_q;
   assign bus.m_wdata         = m_wdata_q;
   assign bus.r0_gnt          = r0_gnt;
   assign bus.r1_gnt          = r1_gnt;
   assign bus.r0_rvalid       = pop && !head_tag;
   assign bus.r1_rvalid       = pop && head_tag;
   assign bus.r_rdata         = pop ? bus.m_rdata : '0;
   assign bus.err_ref_overrun = err_ovr_q;
   assign bus.err_orphan      = err_orph_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter: refresh, grants, read routing, tag stall, starvation, errors.
module tb_sdram_arbiter;

   localparam int unsigned ADDR_W         = 24;
   localparam int unsigned REFRESH_PERIOD = 515;

   logic clk = 1'b0;
   logic rst;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   sdram_arbiter #(
      .ADDR_W         (ADDR_W),
      .REFRESH_PERIOD (REFRESH_PERIOD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.r0_req   = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
      bus.r1_req   = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
      bus.m_ready  = 1'b1;
      bus.m_rvalid = 1'b0;
      bus.m_rdata  = '0;
   endtask

   // Returns at a falling edge with reset just released; the next rising edge is cycle 1.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   int unsigned ref_cnt, ref_cyc, gnt_cnt, r0_cnt, r1_cnt, r0_before, r0_between;

   initial begin
      rst = 1'b1;
      clear_inputs();

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_ctrl", {bus.m_valid, bus.m_refresh, bus.m_we, bus.r0_gnt, bus.r1_gnt,
                            bus.r0_rvalid, bus.r1_rvalid, bus.err_ref_overrun, bus.err_orphan}, 0);
      check_eq("rst_addr",  bus.m_addr, 0);
      check_eq("rst_wdata", bus.m_wdata, 0);
      check_eq("rst_rdata", bus.r_rdata, 0);

      // Idle for 600 cycles: exactly one refresh, at cycle 516
      @(negedge clk);
      rst = 1'b0;
      ref_cnt = 0; ref_cyc = 0; gnt_cnt = 0;
      for (int i = 1; i <= 600; i++) begin
         cyc();
         if (bus.m_valid && bus.m_refresh && bus.m_ready) begin
            ref_cnt++;
            if (ref_cyc == 0) ref_cyc = i;
         end
         if (bus.r0_gnt || bus.r1_gnt) gnt_cnt++;
      end
      check_eq("idle_ref_count", ref_cnt, 1);
      check_eq("idle_ref_cycle", ref_cyc, 516);
      check_eq("idle_gnt_count", gnt_cnt, 0);
      check_eq("idle_errs", {bus.err_ref_overrun, bus.err_orphan}, 0);

      // r0 write
      do_reset();
      bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 24'h000010; bus.r0_wdata = 16'hBEEF;
      #1;
      check_eq("wr_mvalid_pre", bus.m_valid, 0);
      cyc();
      check_eq("wr_mvalid", {bus.m_valid, bus.m_refresh, bus.m_we}, 3'b101);
      check_eq("wr_addr",   bus.m_addr, 32'h10);
      check_eq("wr_wdata",  bus.m_wdata, 32'hBEEF);
      check_eq("wr_gnt",    {bus.r0_gnt, bus.r1_gnt}, 2'b10);
      bus.r0_req = 1'b0;
      cyc();
      check_eq("wr_gnt_pulse", {bus.m_valid, bus.r0_gnt}, 0);

      // r0 read then r1 read, data routed back in order
      do_reset();
      bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 24'h000020;
      bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 24'h000030;
      cyc();
      check_eq("rd_r0_addr", bus.m_addr, 32'h20);
      check_eq("rd_r0_gnt",  {bus.r0_gnt, bus.r1_gnt, bus.m_we}, 3'b100);
      bus.r0_req = 1'b0;
      cyc();
      check_eq("rd_idle_gap", bus.m_valid, 0);
      cyc();
      check_eq("rd_r1_addr", bus.m_addr, 32'h30);
      check_eq("rd_r1_gnt",  {bus.r0_gnt, bus.r1_gnt}, 2'b01);
      bus.r1_req = 1'b0;
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 16'h1111;
      #1;
      check_eq("rd_ret0_valid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b10);
      check_eq("rd_ret0_data",  bus.r_rdata, 32'h1111);
      cyc();
      bus.m_rdata = 16'h2222;
      #1;
      check_eq("rd_ret1_valid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b01);
      check_eq("rd_ret1_data",  bus.r_rdata, 32'h2222);
      bus.m_rvalid = 1'b0;
      cyc();
      check_eq("rd_ret_done", {bus.r0_rvalid, bus.r1_rvalid, bus.err_orphan}, 0);
      check_eq("rd_rdata_zero", bus.r_rdata, 0);

      // Five r1 reads with no returns: tag FIFO fills after four
      do_reset();
      bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 24'h000040;
      r1_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (bus.r1_gnt) r1_cnt++;
      end
      check_eq("full_gnt_count", r1_cnt, 4);
      check_eq("full_stalled",   bus.m_valid, 0);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 16'hABCD;
      #1;
      check_eq("full_ret_valid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b01);
      check_eq("full_ret_data",  bus.r_rdata, 32'hABCD);
      r1_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         bus.m_rvalid = 1'b0;
         #1;
         if (bus.r1_gnt) r1_cnt++;
      end
      check_eq("full_resume_gnt", r1_cnt, 1);
      bus.r1_req = 1'b0;

      // Both requesters writing continuously for 200 cycles
      do_reset();
      bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 24'h000001;
      bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 24'h000002;
      r0_cnt = 0; r1_cnt = 0; r0_before = 0; r0_between = 0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (bus.r0_gnt) begin
            r0_cnt++;
            if (r1_cnt == 0) r0_before++;
            if (r1_cnt == 1) r0_between++;
         end
         if (bus.r1_gnt) r1_cnt++;
      end
      check_eq("both_total_gnt", r0_cnt + r1_cnt, 100);
`ifdef SDRAM_ARB_STARVE_EN
      check_eq("starve_first",   r0_before, 16);
      check_eq("starve_between", r0_between, 16);
      check_eq("starve_r1_cnt",  r1_cnt, 5);
`else
      check_eq("prio_r1_cnt",    r1_cnt, 0);
      check_eq("prio_r0_cnt",    r0_cnt, 100);
`endif
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;

      // Controller stalled: refresh overrun, then an orphan read return
      do_reset();
      bus.m_ready = 1'b0;
      repeat (600) cyc();
      check_eq("ovr_not_yet", bus.err_ref_overrun, 0);
      check_eq("ovr_ref_held", {bus.m_valid, bus.m_refresh}, 2'b11);
      repeat (500) cyc();
      check_eq("ovr_set", bus.err_ref_overrun, 1);
      bus.m_ready = 1'b1;
      repeat (4) cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 16'h5555;
      #1;
      check_eq("orph_no_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      check_eq("orph_pre", bus.err_orphan, 0);
      cyc();
      bus.m_rvalid = 1'b0;
      #1;
      check_eq("orph_set", bus.err_orphan, 1);
      check_eq("ovr_sticky", bus.err_ref_overrun, 1);

      // Reset with a read outstanding discards its tag
      do_reset();
      bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 24'h000050;
      cyc();
      check_eq("mid_gnt", bus.r0_gnt, 1);
      bus.r0_req = 1'b0;
      cyc();
      do_reset();
      #1;
      check_eq("mid_cleared", {bus.m_valid, bus.err_orphan, bus.err_ref_overrun}, 0);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 16'h7777;
      #1;
      check_eq("mid_no_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      cyc();
      bus.m_rvalid = 1'b0;
      #1;
      check_eq("mid_orphan", bus.err_orphan, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
